result_bram_to_stream: RTL and testbench
========================================

RESULT_BRAM_TO_STREAM -- requirements
Module: result_bram_to_stream

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all state is reset asynchronously.
REQ-002 SHALL expose: i_clk  in  1  clock.
REQ-003 SHALL expose: i_reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL expose: o_bram_rd_addr  out  9  result BRAM line address (0-511).
REQ-005 SHALL expose: o_bram_rd_en  out  1  BRAM read enable; data valid the cycle after.
REQ-006 SHALL expose: i_bram_rd_data  in  256  BRAM line; FP16 k at bits [16k+15:16k].
REQ-007 SHALL expose: i_wr_ptr  in  13  writer pointer (next FP16 slot to be written).
REQ-008 SHALL expose: o_rd_ptr  out  13  next FP16 index not yet consumed; fed to the writer.
REQ-009 SHALL expose: o_used_entries  out  14  entries in the buffer not yet consumed (0-8191).
REQ-010 SHALL expose: i_read_top_reset  in  1  synchronous host clear of the read side.
REQ-011 SHALL expose: o_data  out  16  FP16 result stream data.
REQ-012 SHALL expose: o_valid  out  1  stream valid.
REQ-013 SHALL expose: i_ready  in  1  stream ready; handshake = o_valid && i_ready.

Function
REQ-014 SHALL register i_wr_ptr once (wr_ptr_q); all availability decisions use wr_ptr_q only. This covers the writer's one-cycle BRAM write lag.
REQ-015 SHALL compute o_used_entries = (wr_ptr_q - o_rd_ptr) mod 8192, zero-extended to 14 bits; empty = (wr_ptr_q == o_rd_ptr).
REQ-016 SHALL implement FSM states IDLE, FETCH, WAIT, STREAM.
  - IDLE -> FETCH when the entry at o_rd_ptr is not buffered and not empty.
  - FETCH: o_bram_rd_en = 1 for exactly one cycle; o_bram_rd_addr = o_rd_ptr[12:4].
  - WAIT: capture i_bram_rd_data into the line buffer.
  - STREAM: emit entries from the line buffer.
REQ-017 SHALL record snap = wr_ptr_q when the read is issued.
  - If snap[12:4] == line address, trusted entries are [o_rd_ptr, snap).
  - Otherwise, trusted entries run to line position 15.
REQ-018 SHALL load o_data/o_valid from the buffer entry at o_rd_ptr[3:0] (the captured line or the line buffer) when o_valid==0 or a handshake occurs and that entry is trusted.
REQ-019 SHALL hold o_data stable and o_valid high until the handshake; the only exception is i_read_top_reset.
REQ-020 SHALL increment o_rd_ptr by 1 on each handshake, wrapping 8191 -> 0.
REQ-021 SHALL, on handshake of the last trusted entry:
  - if the next entry is available: issue the next fetch at that same edge (o_valid low for 2 cycles);
  - otherwise: go to IDLE with o_valid low.
REQ-022 SHALL refetch the same line from IDLE when wr_ptr_q advances past snap within that line (partial-line refill).
REQ-023 SHALL have latency: i_wr_ptr changes at edge E0 on an empty, idle reader -> o_valid high after edge E4. Steady state within a line is 1 FP16/cycle.
REQ-024 SHALL, on i_read_top_reset (priority over all else):
  - o_rd_ptr <= 0, o_valid <= 0, line buffer invalid, state <= IDLE;
  - any in-flight read data is discarded.
REQ-025 SHALL never issue a BRAM read while i_read_top_reset is high.

Reset
REQ-026 SHALL reset to: o_rd_ptr=0, wr_ptr_q=0, o_valid=0, o_data=0, o_bram_rd_en=0, o_bram_rd_addr=0, state=IDLE, line buffer invalid, snap=0; o_used_entries therefore 0.
REQ-027 SHALL, when reset is asserted mid-fetch or mid-stream, drop outstanding reads and not assert o_valid until new data per REQ-023.

Structure
REQ-028 SHALL take from shared package result_buf_pkg: RESULT_CAPACITY=8192, PTR_W=13, LINE_ADDR_W=9, LINE_W=256, FP16_PER_LINE=16, ALMOST_FULL_THRESHOLD=7936, and the FSM state enum.
REQ-029 SHALL be a single module with no sub-modules; FP16 lane select is inline.

Verification
REQ-030 Single entry: i_wr_ptr 0->1, i_ready=1 -> one read of line 0, o_valid high after E4, o_data=entry 0, o_rd_ptr=1, then o_valid low.
REQ-031 Full line plus crossing: 20 entries preloaded, i_ready=1 -> entries 0-15 back-to-back, 2-cycle o_valid gap, entries 16-19, o_rd_ptr=20.
REQ-032 Backpressure: i_ready=0 for 10 cycles mid-line -> o_data/o_valid stable, o_rd_ptr unchanged, no extra BRAM reads.
REQ-033 Partial-line refill: i_wr_ptr=3, drain, then i_wr_ptr=5 -> line 0 refetched, entries 3,4 delivered with correct values.
REQ-034 Wrap: o_rd_ptr=8190, i_wr_ptr=2 -> reads line 511 then line 0, o_rd_ptr sequence 8191,0,1,2, o_used_entries=4 at start.
REQ-035 Host clear mid-fetch: i_read_top_reset during WAIT -> o_valid stays 0, o_rd_ptr=0, and the captured data is not emitted.

Source files
------------

// File: rtl/result_buf_pkg.sv
// Shared constants and FSM state encoding for the result buffer read side.
package result_buf_pkg;

  localparam int RESULT_CAPACITY       = 8192;
  localparam int PTR_W                 = 13;
  localparam int LINE_ADDR_W           = 9;
  localparam int LINE_W                = 256;
  localparam int FP16_PER_LINE         = 16;
  localparam int ALMOST_FULL_THRESHOLD = 7936;
  localparam int FP16_W                = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    WAIT   = 2'd2,
    STREAM = 2'd3
  } state_t;

endpackage

// File: rtl/result_bram_to_stream_if.sv
// BRAM read port plus FP16 result stream, bundled as one bus.
// The master side is the reader; the slave side is the BRAM and the stream sink.
interface result_bram_to_stream_if;
  import result_buf_pkg::*;

  logic [LINE_ADDR_W-1:0] o_bram_rd_addr;
  logic                   o_bram_rd_en;
  logic [LINE_W-1:0]      i_bram_rd_data;
  logic [FP16_W-1:0]      o_data;
  logic                   o_valid;
  logic                   i_ready;

  modport master (
    output o_bram_rd_addr, o_bram_rd_en, o_data, o_valid,
    input  i_bram_rd_data, i_ready
  );

  modport slave (
    input  o_bram_rd_addr, o_bram_rd_en, o_data, o_valid,
    output i_bram_rd_data, i_ready
  );

endinterface

// File: rtl/result_bram_to_stream.sv
// Reads FP16 results out of the 256-bit result BRAM one line at a time and
// presents them as a valid/ready stream. Entries are only emitted once the
// registered writer pointer shows them written; a line fetched while the
// writer was still inside it is trusted only up to the pointer seen at fetch.
module result_bram_to_stream
  import result_buf_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [PTR_W-1:0]        i_wr_ptr,
  output logic [PTR_W-1:0]        o_rd_ptr,
  output logic [PTR_W:0]          o_used_entries,
  input  logic                    i_read_top_reset,
  result_bram_to_stream_if.master bus
);

  localparam int POS_W = PTR_W - LINE_ADDR_W;

  state_t                 state, state_nxt;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr, rd_ptr_inc, snap;
  logic [LINE_W-1:0]      line_buf;
  logic [LINE_ADDR_W-1:0] buf_line;
  logic                   buf_vld;
  logic [FP16_W-1:0]      data_q;
  logic                   valid_q;
  logic                   hs, empty, buffered, cont, more;
  logic                   fetch_go, capture, load_buf, drop_valid;
  logic [POS_W-1:0]       lane_pos;
  logic [LINE_W-1:0]      lane_src;
  logic [FP16_W-1:0]      lane_data;

  assign hs         = valid_q & bus.i_ready;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);
  assign empty      = (wr_ptr_q == rd_ptr);
  // The buffered line is good from the current entry up to (not including) snap.
  assign buffered   = buf_vld && (rd_ptr[PTR_W-1:POS_W] == buf_line) && (rd_ptr != snap);
  // Next entry still inside the current line and below the trusted limit.
  assign cont       = (rd_ptr_inc[POS_W-1:0] != '0) && (rd_ptr_inc != snap);
  assign more       = (wr_ptr_q != rd_ptr_inc);

  // While streaming the entry to load is the one after the handshake; otherwise
  // it is the entry at the pointer. In WAIT the line comes straight off the BRAM.
  assign lane_pos  = (state == STREAM) ? rd_ptr_inc[POS_W-1:0] : rd_ptr[POS_W-1:0];
  assign lane_src  = (state == WAIT) ? bus.i_bram_rd_data : line_buf;
  assign lane_data = lane_src[{lane_pos, 4'b0000} +: FP16_W];

  assign bus.o_bram_rd_en   = (state == FETCH) && !i_read_top_reset;
  assign bus.o_bram_rd_addr = rd_ptr[PTR_W-1:POS_W];
  assign bus.o_data         = data_q;
  assign bus.o_valid        = valid_q;
  assign o_rd_ptr           = rd_ptr;
  assign o_used_entries     = {1'b0, wr_ptr_q - rd_ptr};

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state and datapath control decode; host clear overrides everything.
  always_comb begin
    state_nxt  = state;
    fetch_go   = 1'b0;
    capture    = 1'b0;
    load_buf   = 1'b0;
    drop_valid = 1'b0;
    if (i_read_top_reset) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            if (buffered) begin
              load_buf  = 1'b1;
              state_nxt = STREAM;
            end else begin
              fetch_go  = 1'b1;
              state_nxt = FETCH;
            end
          end
        end
        FETCH: state_nxt = WAIT;
        WAIT: begin
          capture   = 1'b1;
          state_nxt = STREAM;
        end
        STREAM: begin
          if (hs) begin
            if (cont) begin
              load_buf = 1'b1;
            end else begin
              drop_valid = 1'b1;
              if (more) begin
                fetch_go  = 1'b1;
                state_nxt = FETCH;
              end else begin
                state_nxt = IDLE;
              end
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Pointers, fetch snapshot, line buffer and output register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr   <= '0;
      snap     <= '0;
      line_buf <= '0;
      buf_line <= '0;
      buf_vld  <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= i_wr_ptr;
      if (i_read_top_reset) begin
        rd_ptr  <= '0;
        valid_q <= 1'b0;
        buf_vld <= 1'b0;
      end else begin
        if (hs)       rd_ptr <= rd_ptr_inc;
        if (fetch_go) snap   <= wr_ptr_q;
        if (capture) begin
          line_buf <= bus.i_bram_rd_data;
          buf_line <= rd_ptr[PTR_W-1:POS_W];
          buf_vld  <= 1'b1;
        end
        if (capture || load_buf) begin
          data_q  <= lane_data;
          valid_q <= 1'b1;
        end else if (drop_valid) begin
          valid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_bram_to_stream.sv
// Directed bench for result_bram_to_stream: a BRAM model with one-cycle read
// latency, a scoreboard queue filled as entries are written, and a monitor
// that pops and compares on every stream handshake.
module tb_result_bram_to_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] wr_ptr;
  logic [12:0] rd_ptr;
  logic [13:0] used;
  logic        clr;

  result_bram_to_stream_if bus();

  result_bram_to_stream dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_wr_ptr         (wr_ptr),
    .o_rd_ptr         (rd_ptr),
    .o_used_entries   (used),
    .i_read_top_reset (clr),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] idx;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [8:0]  addr_log[$];
  logic [15:0] mem [0:8191];
  int          hs_cyc [0:8191];
  int          checks   = 0;
  int          passes   = 0;
  int          rd_cnt   = 0;
  int          cyc      = 0;
  int          last_idx = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input int idx, input logic [15:0] v);
    exp_t e;
    mem[idx] = v;
    e.idx = 13'(idx);
    e.data = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.o_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, 32'(n >= budget), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic host_clear();
    tick();
    clr = 1'b1;
    wr_ptr = 13'd0;
    tick();
    clr = 1'b0;
    @(negedge clk);
    chk("clear_valid", bus.o_valid, 0);
    chk("clear_rd_ptr", rd_ptr, 0);
    chk("clear_used", used, 0);
  endtask

  // BRAM model with one-cycle read latency, plus a free-running cycle count.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_bram_rd_en)
      for (int k = 0; k < 16; k++)
        bus.i_bram_rd_data[16*k +: 16] <= mem[{bus.o_bram_rd_addr, k[3:0]}];
  end

  // Monitor: log reads, police reads during host clear, score every handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_bram_rd_en) begin
        rd_cnt++;
        addr_log.push_back(bus.o_bram_rd_addr);
      end
      if (clr) chk("no_read_during_clear", bus.o_bram_rd_en, 0);
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {3'b0, rd_ptr, bus.o_data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("stream_entry", {3'b0, rd_ptr, bus.o_data}, {3'b0, e.idx, e.data});
          hs_cyc[e.idx] = cyc;
          last_idx = int'(e.idx);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0;
    rst_n = 1'b0;
    clr = 1'b0;
    wr_ptr = 13'd0;
    bus.i_ready = 1'b1;
    bus.i_bram_rd_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", bus.o_valid, 0);
    chk("reset_data", bus.o_data, 0);
    chk("reset_rd_ptr", rd_ptr, 0);
    chk("reset_used", used, 0);
    chk("reset_rd_en", bus.o_bram_rd_en, 0);
    chk("reset_rd_addr", bus.o_bram_rd_addr, 0);

    // Single entry and first-data latency.
    push(0, 16'h3C00);
    tick();
    wr_ptr = 13'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("latency_e3_valid_low", bus.o_valid, 0);
    @(negedge clk);
    chk("latency_e4_valid_high", bus.o_valid, 1);
    chk("single_data", bus.o_data, 16'h3C00);
    wait_drain("single", 50);
    chk("single_rd_ptr", rd_ptr, 1);
    chk("single_reads", rd_cnt, 1);
    chk("single_addr", addr_log[$], 0);
    chk("single_used", used, 0);

    // Full line plus crossing into the next line.
    host_clear();
    for (int i = 0; i < 20; i++) push(i, 16'h1000 + 16'(i));
    tick();
    wr_ptr = 13'd20;
    wait_drain("cross", 200);
    chk("cross_rd_ptr", rd_ptr, 20);
    chk("cross_line0_burst", hs_cyc[15] - hs_cyc[0], 15);
    chk("cross_gap", hs_cyc[16] - hs_cyc[15], 3);
    chk("cross_line1_burst", hs_cyc[19] - hs_cyc[16], 3);
    chk("cross_reads", rd_cnt, 3);

    // Backpressure mid-line.
    for (int i = 20; i < 32; i++) push(i, 16'h2000 + 16'(i * 7));
    tick();
    wr_ptr = 13'd32;
    n = 0;
    while (last_idx < 24 && n < 100) begin
      tick();
      n++;
    end
    chk("bp_reach_timeout", 32'(n >= 100), 0);
    bus.i_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 || bus.o_data !== exp_q[0].data || bus.o_valid !== 1'b1 || rd_ptr !== 13'd25)
        bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_data", bus.o_data, 16'h20AF);
    chk("bp_rd_ptr", rd_ptr, 25);
    chk("bp_reads", rd_cnt, 4);
    tick();
    bus.i_ready = 1'b1;
    wait_drain("bp", 200);
    chk("bp_final_rd_ptr", rd_ptr, 32);

    // Partial-line refill.
    host_clear();
    for (int i = 0; i < 3; i++) push(i, 16'h3000 + 16'(i));
    tick();
    wr_ptr = 13'd3;
    wait_drain("partial_a", 100);
    chk("partial_a_rd_ptr", rd_ptr, 3);
    push(3, 16'h4A03);
    push(4, 16'h4A04);
    tick();
    wr_ptr = 13'd5;
    wait_drain("partial_b", 100);
    chk("partial_b_rd_ptr", rd_ptr, 5);
    chk("partial_reads", rd_cnt, 6);
    chk("partial_addr_first", addr_log[addr_log.size()-2], 0);
    chk("partial_addr_refetch", addr_log[addr_log.size()-1], 0);

    // Advance to 8190, then wrap through the end of the buffer.
    for (int i = 5; i < 8190; i++) push(i, 16'(i) ^ 16'h5A5A);
    tick();
    wr_ptr = 13'd8190;
    wait_drain("bulk", 20000);
    chk("bulk_rd_ptr", rd_ptr, 8190);
    chk("bulk_reads", rd_cnt, 518);
    push(8190, 16'hA001);
    push(8191, 16'hA002);
    push(0, 16'hA003);
    push(1, 16'hA004);
    tick();
    wr_ptr = 13'd2;
    @(posedge clk);
    @(negedge clk);
    chk("wrap_used_start", used, 4);
    wait_drain("wrap", 200);
    chk("wrap_rd_ptr", rd_ptr, 2);
    chk("wrap_reads", rd_cnt, 520);
    chk("wrap_addr_511", addr_log[addr_log.size()-2], 511);
    chk("wrap_addr_0", addr_log[addr_log.size()-1], 0);
    chk("wrap_used_end", used, 0);

    // Host clear while the read data is in flight.
    mem[2] = 16'hDEAD;
    tick();
    wr_ptr = 13'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("inflight_fetch_issued", bus.o_bram_rd_en, 1);
    @(posedge clk);
    #1;
    clr = 1'b1;
    wr_ptr = 13'd0;
    tick();
    clr = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_valid !== 1'b0) bad++;
    end
    chk("inflight_valid_low", bad, 0);
    chk("inflight_rd_ptr", rd_ptr, 0);
    chk("inflight_used", used, 0);
    chk("inflight_reads", rd_cnt, 521);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
